// File: rtl/outgoing_request_buffer.sv
// outgoing_request_buffer: AR request FIFO toward the AXI slave.
// Issue is throttled by an outstanding-burst limiter. The limiter is credited
// whenever the R path reports a completed burst.
module outgoing_request_buffer #(
    parameter int ID_WIDTH        = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    // request side (from the ID allocator)
    input  logic                                   ar_in_valid,
    output logic                                   ar_in_ready,
    input  logic [ID_WIDTH-1:0]                    ar_in_id,
    input  logic [ADDR_WIDTH-1:0]                  ar_in_addr,
    input  logic [7:0]                             ar_in_len,
    input  logic [2:0]                             ar_in_size,
    input  logic [1:0]                             ar_in_burst,
    // slave AR channel
    output logic                                   ar_out_valid,
    input  logic                                   ar_out_ready,
    output logic [ID_WIDTH-1:0]                    ar_out_id,
    output logic [ADDR_WIDTH-1:0]                  ar_out_addr,
    output logic [7:0]                             ar_out_len,
    output logic [2:0]                             ar_out_size,
    output logic [1:0]                             ar_out_burst,
    // completion credit from the R path
    input  logic                                   r_burst_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_cnt
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int ENTRY_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [OUT_W-1:0] outstanding_reg, outstanding_next;

    logic               push;
    logic               pop;
    logic               can_issue;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] out_entry;
    logic [ENTRY_W-1:0] in_entry;

    assign in_entry    = {ar_in_id, ar_in_addr, ar_in_len, ar_in_size, ar_in_burst};

    // Ready depends on the registered fill level only; a full buffer never
    // accepts, even when an entry leaves in the same cycle.
    assign ar_in_ready = (count_reg != CNT_W'(DEPTH));
    assign push        = ar_in_valid & ar_in_ready;

    assign can_issue    = (outstanding_reg < OUT_W'(MAX_OUTSTANDING));
    assign ar_out_valid = (count_reg != '0) & can_issue;
    assign pop          = ar_out_valid & ar_out_ready;

    // Fields are driven to zero whenever valid is low (empty or throttled).
    assign head_entry = mem[rd_ptr_reg];
    assign out_entry  = ar_out_valid ? head_entry : '0;
    assign {ar_out_id, ar_out_addr, ar_out_len, ar_out_size, ar_out_burst} = out_entry;

    assign outstanding_cnt = outstanding_reg;

    // Per-entry storage write; the slot under wr_ptr captures the request on push.
    // Storage needs no reset: the output mux hides stale contents.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= in_entry;
                end
            end
        end
    endgenerate

    // Next-state for pointers, fill level and the outstanding-burst counter.
    always_comb begin
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;
        outstanding_next = outstanding_reg;

        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        // A pop only happens below the limit, so +1 never exceeds it.
        // A credit with nothing outstanding is dropped rather than wrapping.
        case ({pop, r_burst_done})
            2'b10:   outstanding_next = outstanding_reg + OUT_W'(1);
            2'b01:   outstanding_next = (outstanding_reg != '0) ?
                                        outstanding_reg - OUT_W'(1) : outstanding_reg;
            default: outstanding_next = outstanding_reg;
        endcase
    end

    // State registers with synchronous active-low reset; reset drops all entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            outstanding_reg <= '0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
        end
    end

endmodule

// File: tb/tb_outgoing_request_buffer.sv
// tb_outgoing_request_buffer: directed self-checking bench for the AR request FIFO.
module tb_outgoing_request_buffer;

    logic        clk;
    logic        rst;
    logic        ar_in_valid;
    logic        ar_in_ready;
    logic [31:0] ar_in_id;
    logic [31:0] ar_in_addr;
    logic [7:0]  ar_in_len;
    logic [2:0]  ar_in_size;
    logic [1:0]  ar_in_burst;
    logic        ar_out_valid;
    logic        ar_out_ready;
    logic [31:0] ar_out_id;
    logic [31:0] ar_out_addr;
    logic [7:0]  ar_out_len;
    logic [2:0]  ar_out_size;
    logic [1:0]  ar_out_burst;
    logic        r_burst_done;
    logic [2:0]  outstanding_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    outgoing_request_buffer #(
        .ID_WIDTH        (32),
        .ADDR_WIDTH      (32),
        .DEPTH           (8),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ar_in_valid     (ar_in_valid),
        .ar_in_ready     (ar_in_ready),
        .ar_in_id        (ar_in_id),
        .ar_in_addr      (ar_in_addr),
        .ar_in_len       (ar_in_len),
        .ar_in_size      (ar_in_size),
        .ar_in_burst     (ar_in_burst),
        .ar_out_valid    (ar_out_valid),
        .ar_out_ready    (ar_out_ready),
        .ar_out_id       (ar_out_id),
        .ar_out_addr     (ar_out_addr),
        .ar_out_len      (ar_out_len),
        .ar_out_size     (ar_out_size),
        .ar_out_burst    (ar_out_burst),
        .r_burst_done    (r_burst_done),
        .outstanding_cnt (outstanding_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic push_one(input logic [31:0] id, input logic [31:0] addr);
        ar_in_valid = 1'b1;
        ar_in_id    = id;
        ar_in_addr  = addr;
        ar_in_len   = id[7:0];
        ar_in_size  = 3'd2;
        ar_in_burst = 2'd1;
        tick();
        ar_in_valid = 1'b0;
    endtask

    int unsigned pushed;
    int unsigned popped;
    int unsigned exp_out;
    int unsigned cyc;
    logic        do_pop;
    logic        stall_prev;
    logic [31:0] prev_id;
    logic [31:0] prev_addr;
    logic [31:0] issued [$];

    initial begin
        rst          = 1'b0;
        ar_in_valid  = 1'b0;
        ar_in_id     = '0;
        ar_in_addr   = '0;
        ar_in_len    = '0;
        ar_in_size   = '0;
        ar_in_burst  = '0;
        ar_out_ready = 1'b0;
        r_burst_done = 1'b0;

        // ---- reset state
        tick();
        do_reset();
        $display("[TB] reset");
        check("rst_ready", 64'(ar_in_ready), 64'(1));
        check("rst_valid", 64'(ar_out_valid), 64'(0));
        check("rst_id",    64'(ar_out_id), 64'(0));
        check("rst_addr",  64'(ar_out_addr), 64'(0));
        check("rst_cnt",   64'(outstanding_cnt), 64'(0));

        // ---- fill to full with the slave stalled
        for (int i = 0; i < 8; i++) begin
            push_one(32'(i), 32'h100 + 32'(i));
            $display("[TB] push id=%0d ready=%0b", i, ar_in_ready);
            if (i == 0) begin
                check("first_visible_valid", 64'(ar_out_valid), 64'(1));
                check("first_visible_id",    64'(ar_out_id), 64'(0));
            end
        end
        check("full_ready", 64'(ar_in_ready), 64'(0));
        push_one(32'd99, 32'h999);
        $display("[TB] 9th push attempted ready=%0b", ar_in_ready);
        check("full_ready_hold", 64'(ar_in_ready), 64'(0));

        // ---- drain with a credit every cycle (pop+credit keeps outstanding at 0)
        ar_out_ready = 1'b1;
        r_burst_done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain_valid", 64'(ar_out_valid), 64'(1));
            check("drain_id",    64'(ar_out_id), 64'(k));
            check("drain_addr",  64'(ar_out_addr), 64'(32'h100 + 32'(k)));
            $display("[TB] pop id=%0d", ar_out_id);
            tick();
        end
        check("drain_empty", 64'(ar_out_valid), 64'(0));
        check("drain_cnt",   64'(outstanding_cnt), 64'(0));
        ar_out_ready = 1'b0;
        r_burst_done = 1'b0;

        // ---- throttle at MAX_OUTSTANDING
        do_reset();
        for (int i = 0; i < 6; i++) push_one(32'(i), 32'h200 + 32'(i));
        ar_out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (ar_out_valid) begin
                issued.push_back(ar_out_id);
                $display("[TB] issue id=%0d", ar_out_id);
            end
            tick();
        end
        check("throttle_issued", 64'(issued.size()), 64'(4));
        for (int i = 0; i < issued.size() && i < 4; i++) check("throttle_order", 64'(issued[i]), 64'(i));
        check("throttle_valid", 64'(ar_out_valid), 64'(0));
        check("throttle_cnt",   64'(outstanding_cnt), 64'(4));

        r_burst_done = 1'b1;
        tick();
        r_burst_done = 1'b0;
        check("credit_valid", 64'(ar_out_valid), 64'(1));
        check("credit_id",    64'(ar_out_id), 64'(4));
        check("credit_cnt_dip", 64'(outstanding_cnt), 64'(3));
        tick();
        $display("[TB] credit issued id=4 cnt=%0d", outstanding_cnt);
        check("credit_cnt", 64'(outstanding_cnt), 64'(4));
        check("credit_valid_after", 64'(ar_out_valid), 64'(0));

        // ---- bring outstanding to 2, then pop and credit together
        ar_out_ready = 1'b0;
        r_burst_done = 1'b1;
        tick();
        tick();
        r_burst_done = 1'b0;
        check("two_cnt", 64'(outstanding_cnt), 64'(2));
        check("two_head", 64'(ar_out_id), 64'(5));
        ar_out_ready = 1'b1;
        r_burst_done = 1'b1;
        tick();
        ar_out_ready = 1'b0;
        r_burst_done = 1'b0;
        $display("[TB] pop+credit cnt=%0d", outstanding_cnt);
        check("popcredit_cnt",   64'(outstanding_cnt), 64'(2));
        check("popcredit_empty", 64'(ar_out_valid), 64'(0));

        // ---- credit with nothing outstanding is ignored
        r_burst_done = 1'b1;
        tick();
        tick();
        check("zero_cnt_pre", 64'(outstanding_cnt), 64'(0));
        tick();
        r_burst_done = 1'b0;
        $display("[TB] spurious credit cnt=%0d", outstanding_cnt);
        check("sat_cnt",   64'(outstanding_cnt), 64'(0));
        check("sat_valid", 64'(ar_out_valid), 64'(0));
        check("sat_ready", 64'(ar_in_ready), 64'(1));

        // ---- stream 20 requests with random stalls and credits
        do_reset();
        pushed     = 0;
        popped     = 0;
        exp_out    = 0;
        stall_prev = 1'b0;
        prev_id    = '0;
        prev_addr  = '0;
        cyc        = 0;
        while (popped < 20 && cyc < 2000) begin
            if (stall_prev) begin
                check("stable_valid", 64'(ar_out_valid), 64'(1));
                check("stable_id",    64'(ar_out_id), 64'(prev_id));
                check("stable_addr",  64'(ar_out_addr), 64'(prev_addr));
            end
            ar_out_ready = ($urandom_range(0, 2) != 0);
            r_burst_done = ($urandom_range(0, 2) == 0);
            ar_in_valid  = (pushed < 20) && ($urandom_range(0, 3) != 0);
            ar_in_id     = 32'(pushed);
            ar_in_addr   = 32'h1000 + 32'h40 * 32'(pushed);
            ar_in_len    = 8'(pushed);
            ar_in_size   = 3'd3;
            ar_in_burst  = 2'd1;
            if (ar_in_valid && ar_in_ready) pushed++;
            do_pop = ar_out_valid && ar_out_ready;
            if (do_pop) begin
                $display("[TB] stream pop id=%0d addr=0x%0h", ar_out_id, ar_out_addr);
                check("stream_id",   64'(ar_out_id), 64'(popped));
                check("stream_addr", 64'(ar_out_addr), 64'(32'h1000 + 32'h40 * 32'(popped)));
                check("stream_len",  64'(ar_out_len), 64'(popped));
                popped++;
            end
            if (do_pop && !r_burst_done) exp_out++;
            else if (!do_pop && r_burst_done && exp_out != 0) exp_out--;
            stall_prev = ar_out_valid && !ar_out_ready;
            prev_id    = ar_out_id;
            prev_addr  = ar_out_addr;
            tick();
            cyc++;
            check("stream_cnt", 64'(outstanding_cnt), 64'(exp_out));
        end
        ar_in_valid  = 1'b0;
        ar_out_ready = 1'b0;
        r_burst_done = 1'b0;
        check("stream_all_popped", 64'(popped), 64'(20));

        // ---- reset mid-operation: 5 buffered, 3 outstanding
        r_burst_done = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        r_burst_done = 1'b0;
        for (int i = 0; i < 8; i++) push_one(32'h20 + 32'(i), 32'h300 + 32'(i));
        ar_out_ready = 1'b1;
        tick();
        tick();
        tick();
        ar_out_ready = 1'b0;
        check("pre_rst_cnt",   64'(outstanding_cnt), 64'(3));
        check("pre_rst_head",  64'(ar_out_id), 64'(32'h23));
        do_reset();
        $display("[TB] mid-op reset valid=%0b ready=%0b cnt=%0d", ar_out_valid, ar_in_ready, outstanding_cnt);
        check("midrst_valid", 64'(ar_out_valid), 64'(0));
        check("midrst_ready", 64'(ar_in_ready), 64'(1));
        check("midrst_cnt",   64'(outstanding_cnt), 64'(0));
        push_one(32'h77, 32'h7700);
        check("midrst_next_valid", 64'(ar_out_valid), 64'(1));
        check("midrst_next_id",    64'(ar_out_id), 64'(32'h77));
        check("midrst_next_addr",  64'(ar_out_addr), 64'(32'h7700));

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
